// File: rtl/cache_bus_arbiter_pkg.sv
// cache_bus_arbiter_pkg: shared FSM states and one-hot owner encodings for the I$/D$ line-transfer arbiter
package cache_bus_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_OWN_I, ST_OWN_D, ST_DONE} state_t;
  localparam logic [1:0] OWN_I = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;
endpackage

// File: rtl/cache_bus_arbiter_beat_counter.sv
// cache_bus_arbiter_beat_counter: per-transfer beat index with clear and last-beat flag
module cache_bus_arbiter_beat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + W'(1);
  assign last = &count;
endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: grants the shared burst line port to I$ or D$, counts beats and acks the owner;
// a D$ writeback locks the next grant so its fill cannot be preempted by the I$.
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int PA_BITS = 34,
  parameter int LINELEN = 512,
  parameter int BUSW    = 64,
  parameter int LOGBWPL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         ICacheBusRW,
  input  logic [PA_BITS-1:0] ICacheBusAdr,
  input  logic [1:0]         DCacheBusRW,
  input  logic [PA_BITS-1:0] DCacheBusAdr,
  output logic               ICacheBusAck,
  output logic               DCacheBusAck,
  output logic [LOGBWPL-1:0] IBeatCount,
  output logic [LOGBWPL-1:0] DBeatCount,
  output logic               DSelBusBeat,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAdr,
  input  logic               BusBeatDone,
  output logic [1:0]         Owner
);
  localparam logic [PA_BITS-1:0] LINE_MASK = PA_BITS'(LINELEN / 8 - 1);
  state_t state, state_next;
  logic own_d, lat_wr, last_d, dlock, ireq, dreq, grant_d, grant_i, owning, beat_last;
  logic [PA_BITS-1:0] lat_adr;
  logic [LOGBWPL-1:0] beat;
  logic unused;
  assign unused  = ICacheBusRW[0] ^ (BUSW == 0);
  assign ireq    = ICacheBusRW[1];
  assign dreq    = |DCacheBusRW;
  // D wins a tie when locked after its writeback, or when I held the port last
  assign grant_d = dreq & (~ireq | dlock | ~last_d);
  assign grant_i = ireq & ~grant_d;
  assign owning  = (state == ST_OWN_I) | (state == ST_OWN_D);
  cache_bus_arbiter_beat_counter #(.W(LOGBWPL)) u_beat (
    .clk(clk),
    .rst_n(reset),
    .en(owning & BusBeatDone),
    .clr(state == ST_DONE),
    .count(beat),
    .last(beat_last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:            state_next = grant_d ? ST_OWN_D : grant_i ? ST_OWN_I : ST_IDLE;
      ST_OWN_I, ST_OWN_D: state_next = (BusBeatDone & beat_last) ? ST_DONE : state;
      default:            state_next = ST_IDLE;
    endcase
  end
  // Owner request is latched at grant so the transfer is committed regardless of later input changes
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      own_d   <= 1'b0;
      lat_wr  <= 1'b0;
      last_d  <= 1'b0;
      dlock   <= 1'b0;
      lat_adr <= '0;
    end else begin
      if (state == ST_IDLE) begin
        dlock <= 1'b0;
        if (grant_d | grant_i) begin
          own_d   <= grant_d;
          lat_wr  <= grant_d & DCacheBusRW[0];
          lat_adr <= grant_d ? DCacheBusAdr : ICacheBusAdr;
        end
      end
      if (state == ST_DONE) begin
        last_d <= own_d;
        dlock  <= own_d & lat_wr;
      end
    end
  always_comb begin
    Owner        = state == ST_OWN_I ? OWN_I : state == ST_OWN_D ? OWN_D : 2'b00;
    BusReq       = owning;
    BusWrite     = (state == ST_OWN_D) & lat_wr;
    DSelBusBeat  = (state == ST_OWN_D) & lat_wr;
    BusAdr       = owning ? (lat_adr & ~LINE_MASK) : '0;
    IBeatCount   = state == ST_OWN_I ? beat : '0;
    DBeatCount   = state == ST_OWN_D ? beat : '0;
    ICacheBusAck = (state == ST_DONE) & ~own_d;
    DCacheBusAck = (state == ST_DONE) & own_d;
  end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: directed plus randomized transactions checked against a transfer-level grant model
module tb_cache_bus_arbiter;
  logic clk = 1'b0, reset = 1'b0, bdone = 1'b0;
  logic [1:0] irw = '0, drw = '0, owner;
  logic [33:0] iadr = '0, dadr = '0, badr;
  logic iack, dack, dsel, breq, bwr;
  logic [2:0] ibc, dbc;
  int ntests = 0, nfail = 0;
  bit m_last_d = 0, m_lock = 0;
  cache_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .ICacheBusRW(irw), .ICacheBusAdr(iadr),
    .DCacheBusRW(drw), .DCacheBusAdr(dadr),
    .ICacheBusAck(iack), .DCacheBusAck(dack),
    .IBeatCount(ibc), .DBeatCount(dbc),
    .DSelBusBeat(dsel), .BusReq(breq), .BusWrite(bwr), .BusAdr(badr),
    .BusBeatDone(bdone), .Owner(owner)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [33:0] rnd_adr();
    return 34'({$urandom, $urandom});
  endfunction
  function automatic logic [1:0] rnd_drw();
    int r = $urandom_range(0, 2);
    return r == 0 ? 2'b00 : r == 1 ? 2'b01 : 2'b10;
  endfunction
  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, breq, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_adr"}, badr, 0);
    check({tag, "_wr"}, bwr, 0);
    check({tag, "_dsel"}, dsel, 0);
    check({tag, "_acks"}, {iack, dack}, 0);
    check({tag, "_beats"}, {ibc, dbc}, 0);
  endtask
  // One arbitration round starting from IDLE: request, grant, 8 beats with random gaps, ack
  task automatic run_txn(input logic ir, input logic [1:0] dr, input logic [33:0] ia, input logic [33:0] da);
    int w, beats, budget;
    logic wr;
    logic [33:0] ea;
    check("idle_acks", {iack, dack}, 0);
    check("idle_req", breq, 0);
    irw = {ir, 1'($urandom)};
    drw = dr;
    iadr = ia;
    dadr = da;
    bdone = 1'($urandom);
    w = (!ir && dr == 0) ? 0 : dr == 0 ? 1 : !ir ? 2 : (m_lock || !m_last_d) ? 2 : 1;
    wr = (w == 2) && dr == 2'b01;
    ea = ((w == 2) ? da : ia) & ~34'h3F;
    m_lock = 0;
    tick;
    check("owner", owner, w == 1 ? 2'b01 : w == 2 ? 2'b10 : 2'b00);
    check("busreq", breq, w != 0);
    check("buswrite", bwr, wr);
    check("busadr", badr, w != 0 ? ea : 34'h0);
    if (w == 0) begin
      check("idle_beats", {ibc, dbc}, 0);
      bdone = 0;
      return;
    end
    beats = 0;
    budget = 0;
    while (beats < 8 && budget < 100) begin
      check("ibeat", ibc, w == 1 ? beats : 0);
      check("dbeat", dbc, w == 2 ? beats : 0);
      check("dsel", dsel, wr);
      check("hold_adr", badr, ea);
      check("early_ack", {iack, dack}, 0);
      bdone = $urandom_range(0, 2) != 0;
      irw = 2'($urandom);
      drw = rnd_drw();
      iadr = rnd_adr();
      dadr = rnd_adr();
      tick;
      if (bdone) beats++;
      budget++;
    end
    check("burst_in_budget", budget < 100, 1);
    bdone = 0;
    irw = 0;
    drw = 0;
    check("iack", iack, w == 1);
    check("dack", dack, w == 2);
    check("done_req", breq, 0);
    check("done_owner", owner, 0);
    check("done_beats", {ibc, dbc}, 0);
    m_last_d = (w == 2);
    m_lock = wr;
    tick;
  endtask
  initial begin
    repeat (2) tick;
    check_all_zero("reset");
    reset = 1;
    tick;
    run_txn(1, 2'b10, rnd_adr(), 34'h80008000);
    run_txn(1, 2'b10, rnd_adr(), rnd_adr());
    run_txn(1, 2'b00, 34'h80001234, rnd_adr());
    run_txn(1, 2'b01, rnd_adr(), 34'h80004000);
    run_txn(1, 2'b10, rnd_adr(), 34'h80008000);
    run_txn(1, 2'b10, rnd_adr(), rnd_adr());
    irw = 0;
    drw = 2'b10;
    dadr = rnd_adr();
    tick;
    check("rst_pre_owner", owner, 2'b10);
    bdone = 1;
    repeat (3) tick;
    check("rst_pre_beat", dbc, 3);
    reset = 0;
    #1;
    check_all_zero("midburst_reset");
    bdone = 0;
    drw = 0;
    tick;
    check_all_zero("held_reset");
    reset = 1;
    m_last_d = 0;
    m_lock = 0;
    tick;
    run_txn(1, 2'b00, rnd_adr(), rnd_adr());
    for (int n = 0; n < 60; n++) begin
      logic ir;
      logic [1:0] dr;
      ir = 1'($urandom_range(0, 1));
      dr = (m_lock && $urandom_range(0, 3) != 0) ? 2'b10 : rnd_drw();
      run_txn(ir, dr, rnd_adr(), rnd_adr());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
